mem_obi_lsu: RTL and testbench
==============================

// Module: mem_obi_lsu
// PURPOSE
// - MEM-stage load/store unit: takes the MEM-stage control word (MEM_ctrl) and the ALU address and store
//   data from the EX/MEM pipe register, and runs one OBI master transaction per memory instruction.
// - Stalls the pipeline through the hazard unit until the response phase completes.
// - Presents the load result to the MEM/WB pipe register.
// PARAMETERS
// - DW  32  data width (= riscv_pkg::width)
// - AW  32  byte-address width
// PORTS
// - clk         in   1     clock, rising edge
// - rst         in   1     asynchronous, active-high reset
// - mem_ctrl_i  in   2     MEM_ctrl {mem_en, wr}; wr: READ=load, WRITE=store
// - addr_i      in   AW    effective address (RES_alu_out of EX/MEM)
// - wdata_i     in   DW    store data (RS2_data_out of EX/MEM)
// - flush_i     in   1     MEM-stage instruction squashed (HAZARD_ctrl==FLUSH)
// - obi_req_o   out  1     OBI req
// - obi_we_o    out  1     OBI we (1=write)
// - obi_addr_o  out  AW    OBI addr, word aligned ([1:0]=0)
// - obi_wdata_o out  DW    OBI wdata
// - obi_be_o    out  4     OBI byte enable, always 4'hF
// - obi_gnt_i   in   1     OBI gnt
// - obi_rvalid_i in  1     OBI rvalid
// - obi_rdata_i in   DW    OBI rdata
// - stall_o     out  1     request to hazard unit: hold PC, IF/ID, ID/EX, EX/MEM
// - ld_data_o   out  DW    last completed load data (DATA_mem_in of MEM/WB)
// - done_o      out  1     1-cycle pulse: access finished, instruction may retire
// BEHAVIOUR
// - FSM (LSU_state): IDLE, REQ, RESP, DONE.
// - Reset values: state=IDLE, obi_req_o=0, obi_we_o=0, obi_addr_o=0, obi_wdata_o=0, ld_data_o=0, done_o=0.
//   stall_o follows the combinational equation below (0 with mem_en=0).
// - IDLE:
//   - mem_en=1 & !flush_i: latch addr_i[AW-1:2]<<2, wdata_i and wr into output regs; go to REQ.
//   - mem_en=0 or flush_i: stay in IDLE.
// - REQ: obi_req_o=1. Addr, we and wdata are held stable until gnt.
//   - gnt=1: drop req on the next edge and go to RESP.
// - RESP: obi_req_o=0. Wait for rvalid. rvalid is ignored in REQ because OBI guarantees it arrives >=1 cycle after gnt.
//   - rvalid=1 on a load: ld_data_o<=obi_rdata_i.
//   - rvalid=1 on a store: ld_data_o is unchanged.
//   - On rvalid go to DONE.
// - DONE: done_o=1 and stall_o=0, so the pipe advances at this edge. Always go to IDLE; the same mem_en is never
//   re-launched.
// - stall_o = (IDLE & mem_en & !flush_i) | REQ | RESP.
// - Minimum latency (gnt in first REQ cycle, rvalid next cycle): 3 stall cycles, done_o in the 4th cycle.
// - flush_i in REQ or RESP: the bus transaction still completes (OBI cannot be aborted after req).
//   - A squashed load does not update ld_data_o.
//   - Squash is latched in a flag, and done_o is suppressed.
//   - stall_o stays high until DONE.
// - Back-to-back memory instructions: one cycle in IDLE is always inserted between transactions.
// - Reset mid-transaction: go to IDLE immediately and deassert req. The interconnect is reset by the same rst.
// - Misaligned addresses: low bits are dropped silently (no trap in this core).
// STRUCTURE
// - riscv_pkg additions:
//   - typedef enum logic[1:0] LSU_state {LSU_IDLE, LSU_REQ, LSU_RESP, LSU_DONE};
//   - typedef struct packed obi_m_req {req, we, be, addr, wdata};
//   - localparam OBI_BE_FULL = 4'hF.
// - Single module with no sub-module. The FSM and the datapath registers are small enough to live together.
// TESTING
// - Load, gnt same cycle as req, rvalid next cycle, rdata=32'hDEADBEEF, addr_i=32'h104
//   -> obi_addr_o=32'h104; stall_o high 3 cycles; done_o pulse; ld_data_o=32'hDEADBEEF.
// - Store addr_i=32'h203, wdata=32'h12345678, gnt delayed 4 cycles
//   -> req, addr=32'h200 and wdata held stable 5 cycles; we=1; ld_data_o unchanged; 7 stall cycles total.
// - flush_i=1 in RESP of a load with rdata=32'hCAFE0000
//   -> transaction completes; ld_data_o keeps its old value; no done_o; FSM returns to IDLE.
// - Two consecutive loads to 32'h0 and 32'h4
//   -> exactly one IDLE cycle between the gnt phases; ld_data_o updates twice in order.
// - rst asserted while in REQ
//   -> obi_req_o=0 and state IDLE immediately (asynchronous, no clock edge needed); all outputs at reset values.
// - mem_en=0 for 10 cycles with random gnt/rvalid noise
//   -> obi_req_o stays 0, stall_o stays 0, ld_data_o unchanged.

Source files
------------

// File: rtl/mem_obi_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: FSM states, the OBI master
// request bundle and bus constants.
package mem_obi_lsu_pkg;
    localparam int LSU_DW = 32;
    localparam int LSU_AW = 32;
    localparam logic [3:0] OBI_BE_FULL = 4'hF;

    typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_RESP, LSU_DONE} LSU_state;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [3:0]        be;
        logic [LSU_AW-1:0] addr;
        logic [LSU_DW-1:0] wdata;
    } obi_m_req;
endpackage

// File: rtl/mem_obi_lsu_if.sv
// OBI data-bus port between the LSU (master) and the memory interconnect (slave).
interface mem_obi_lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_obi_lsu.sv
// MEM-stage load/store unit: one OBI transaction per memory instruction, with
// pipeline stall until the response arrives and a one-cycle retire pulse.
module mem_obi_lsu
    import mem_obi_lsu_pkg::*;
#(
    parameter int DW = LSU_DW,
    parameter int AW = LSU_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mem_ctrl_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          flush_i,
    mem_obi_lsu_if.master obi,
    output logic          stall_o,
    output logic [DW-1:0] ld_data_o,
    output logic          done_o
);
    LSU_state state_q, state_d;
    obi_m_req bus_q;
    logic     squash_q;
    logic     mem_en, wr, launch;
    logic     unused_addr_lsb;

    assign mem_en          = mem_ctrl_i[1];
    assign wr              = mem_ctrl_i[0];
    assign launch          = (state_q == LSU_IDLE) && mem_en && !flush_i;
    assign unused_addr_lsb = ^addr_i[1:0];

    assign obi.req   = bus_q.req;
    assign obi.we    = bus_q.we;
    assign obi.be    = bus_q.be;
    assign obi.addr  = bus_q.addr;
    assign obi.wdata = bus_q.wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LSU_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                stall_o = mem_en && !flush_i;
                if (launch) state_d = LSU_REQ;
            end
            LSU_REQ: begin
                stall_o = 1'b1;
                if (obi.gnt) state_d = LSU_RESP;
            end
            LSU_RESP: begin
                stall_o = 1'b1;
                if (obi.rvalid) state_d = LSU_DONE;
            end
            LSU_DONE: begin
                // A squashed instruction must not retire, but its bus access still ran.
                done_o  = !squash_q;
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q     <= '0;
            ld_data_o <= '0;
            squash_q  <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: if (launch) begin
                    bus_q.req   <= 1'b1;
                    bus_q.we    <= wr;
                    bus_q.be    <= OBI_BE_FULL;
                    bus_q.addr  <= {addr_i[AW-1:2], 2'b00};
                    bus_q.wdata <= wdata_i;
                    squash_q    <= 1'b0;
                end
                LSU_REQ: begin
                    if (obi.gnt) bus_q.req <= 1'b0;
                    if (flush_i) squash_q  <= 1'b1;
                end
                LSU_RESP: begin
                    if (flush_i) squash_q <= 1'b1;
                    // A flush arriving together with rvalid squashes the write-back too.
                    if (obi.rvalid && !bus_q.we && !squash_q && !flush_i)
                        ld_data_o <= obi.rdata;
                end
                LSU_DONE: squash_q <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_obi_lsu.sv
// Directed bench for mem_obi_lsu: a small OBI slave answers requests with a
// programmable grant delay and a one-cycle response latency.
module tb_mem_obi_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mem_ctrl = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        flush = 1'b0;
    logic        stall, done;
    logic [31:0] ld_data;
    int          errors = 0, checks = 0, cyc = 0;
    int          st, dn, rq, gc, gc_prev;

    mem_obi_lsu_if bus ();

    mem_obi_lsu dut (
        .clk(clk), .rst(rst), .mem_ctrl_i(mem_ctrl), .addr_i(addr), .wdata_i(wdata),
        .flush_i(flush), .obi(bus), .stall_o(stall), .ld_data_o(ld_data), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One memory instruction held by the stalled pipeline until its DONE cycle.
    task automatic run_mem(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_a, input logic [31:0] rd, input int gnt_dly,
                           input bit do_flush, output int stalls, output int dones,
                           output int reqs, output int gnt_cyc);
        bit pend = 0, last = 0, fin = 0;
        stalls = 0; dones = 0; reqs = 0; gnt_cyc = -1;
        for (int i = 0; i < 50 && !fin; i++) begin
            @(negedge clk);
            cyc++;
            mem_ctrl   = {1'b1, wr};
            addr       = a;
            wdata      = wd;
            bus.gnt    = bus.req && (reqs == gnt_dly);
            bus.rvalid = pend;
            bus.rdata  = rd;
            flush      = do_flush && pend;
            if (bus.gnt) gnt_cyc = cyc;
            #1;
            if (stall) stalls++;
            if (done)  dones++;
            if (bus.req) begin
                chk("req_addr", bus.addr, exp_a);
                chk("req_we", bus.we, wr);
                chk("req_wdata", bus.wdata, wd);
                chk("req_be", bus.be, 4'hF);
                reqs++;
            end
            fin  = last;
            last = bus.rvalid;
            pend = bus.gnt;
        end
        if (!fin) chk("txn_timeout", 1, 0);
        flush = 1'b0;
    endtask

    initial begin
        bus.gnt = 0; bus.rvalid = 0; bus.rdata = '0;
        #2;
        chk("rst_req", bus.req, 0);
        chk("rst_we", bus.we, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wdata", bus.wdata, 0);
        chk("rst_ld", ld_data, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk); rst = 0;

        // Load, immediate grant
        run_mem(1'b0, 32'h104, 32'h0, 32'h104, 32'hDEADBEEF, 0, 0, st, dn, rq, gc);
        chk("ld_stalls", st, 3);
        chk("ld_done", dn, 1);
        chk("ld_reqs", rq, 1);
        chk("ld_data", ld_data, 32'hDEADBEEF);

        // Store, misaligned address, grant after 4 waiting cycles
        run_mem(1'b1, 32'h203, 32'h12345678, 32'h200, 32'hFFFF0000, 4, 0, st, dn, rq, gc);
        chk("st_stalls", st, 7);
        chk("st_reqs", rq, 5);
        chk("st_done", dn, 1);
        chk("st_ld_keep", ld_data, 32'hDEADBEEF);

        // Load squashed during its response phase
        run_mem(1'b0, 32'h40, 32'h0, 32'h40, 32'hCAFE0000, 0, 1, st, dn, rq, gc);
        chk("fl_done", dn, 0);
        chk("fl_stalls", st, 3);
        chk("fl_ld_keep", ld_data, 32'hDEADBEEF);
        @(negedge clk); mem_ctrl = 2'b00; #1;
        chk("fl_idle_req", bus.req, 0);
        chk("fl_idle_stall", stall, 0);

        // Back-to-back loads: gnt, RESP, DONE, IDLE, then next gnt
        run_mem(1'b0, 32'h0, 32'h0, 32'h0, 32'h11111111, 0, 0, st, dn, rq, gc);
        gc_prev = gc;
        chk("b2b_ld0", ld_data, 32'h11111111);
        run_mem(1'b0, 32'h4, 32'h0, 32'h4, 32'h22222222, 0, 0, st, dn, rq, gc);
        chk("b2b_gap", gc - gc_prev, 4);
        chk("b2b_ld1", ld_data, 32'h22222222);
        chk("b2b_done", dn, 1);

        // Flush in IDLE blocks the launch
        @(negedge clk); mem_ctrl = 2'b10; flush = 1; addr = 32'h80; #1;
        chk("fli_stall", stall, 0);
        @(negedge clk); mem_ctrl = 2'b00; flush = 0; #1;
        chk("fli_req", bus.req, 0);

        // No memory instruction while the bus wiggles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ctrl   = 2'(i & 1);
            bus.gnt    = 1'($urandom_range(0, 1));
            bus.rvalid = 1'($urandom_range(0, 1));
            bus.rdata  = $urandom;
            #1;
            chk("nz_req", bus.req, 0);
            chk("nz_stall", stall, 0);
            chk("nz_ld", ld_data, 32'h22222222);
        end
        bus.gnt = 0; bus.rvalid = 0;

        // Asynchronous reset while a store waits for grant
        @(negedge clk); mem_ctrl = 2'b11; addr = 32'h300; wdata = 32'hA5A5A5A5;
        @(negedge clk); #1;
        chk("rr_req_pre", bus.req, 1);
        chk("rr_we_pre", bus.we, 1);
        mem_ctrl = 2'b00;
        #1 rst = 1;
        #1;
        chk("rr_req", bus.req, 0);
        chk("rr_we", bus.we, 0);
        chk("rr_addr", bus.addr, 0);
        chk("rr_wdata", bus.wdata, 0);
        chk("rr_ld", ld_data, 0);
        chk("rr_stall", stall, 0);
        chk("rr_done", done, 0);
        @(negedge clk); rst = 0;
        @(negedge clk); #1;
        chk("rr_idle", bus.req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
